// File: rtl/slot_reel_game_ctrl_if.sv
// Player-side signal bundle for the slot game core: buttons and coin in, display data out.
interface slot_reel_game_ctrl_if #(
  parameter int NUM_REELS = 3
);
  logic                   C_IN;
  logic                   GAME_START;
  logic [NUM_REELS-1:0]   STOP;
  logic [4*NUM_REELS-1:0] REEL_VAL;
  logic [6:0]             CREDIT_BIN;
  logic [7:0]             CREDIT_BCD;
  logic [1:0]             STATE;
  logic [1:0]             WIN;

  modport master (
    output C_IN, GAME_START, STOP,
    input  REEL_VAL, CREDIT_BIN, CREDIT_BCD, STATE, WIN
  );
  modport slave (
    input  C_IN, GAME_START, STOP,
    output REEL_VAL, CREDIT_BIN, CREDIT_BCD, STATE, WIN
  );
endinterface

// File: rtl/slot_reel_game_ctrl.sv
// Slot-machine game core: N prescaled reels with stop buttons, saturating credit, win payout.
// Define SLOT_REVERSE_REEL_EN to make odd-indexed reels count down instead of up.
module slot_reel #(
  parameter int DIV     = 4,
  parameter int SYM_MAX = 9,
  parameter bit DOWN    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       run,
  input  logic       stop_edge,
  output logic [3:0] val,
  output logic       frozen
);
  logic [7:0] presc_q, presc_d;
  logic [3:0] val_q, val_d;
  logic       frozen_q, frozen_d;

  always_comb begin
    presc_d  = presc_q;
    val_d    = val_q;
    frozen_d = frozen_q;
    if (clr) begin
      presc_d  = '0;
      frozen_d = 1'b0;
    end else if (run) begin
      if (stop_edge) frozen_d = 1'b1;
      if (presc_q == 8'(DIV - 1)) begin
        presc_d = '0;
        // a stop edge wins over a step landing on the same cycle
        if (!frozen_q && !stop_edge) begin
          if (DOWN) val_d = (val_q == 4'd0) ? 4'(SYM_MAX) : val_q - 4'd1;
          else      val_d = (val_q == 4'(SYM_MAX)) ? 4'd0 : val_q + 4'd1;
        end
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      val_q    <= '0;
      frozen_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      val_q    <= val_d;
      frozen_q <= frozen_d;
    end
  end

  assign val    = val_q;
  assign frozen = frozen_q;
endmodule

module slot_reel_game_ctrl #(
  parameter int NUM_REELS     = 3,
  parameter int SYM_MAX       = 9,
  parameter int SPIN_DIV_BASE = 4,
  parameter int BET           = 1,
  parameter int PAIR_PAYOUT   = 5,
  parameter int ALL_PAYOUT    = 50,
  parameter int CREDIT_MAX    = 99,
  parameter int SHOW_CYCLES   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  slot_reel_game_ctrl_if.slave  io
);
  typedef enum logic [1:0] {IDLE = 2'b00, SPIN = 2'b01, EVAL = 2'b10, SHOW = 2'b11} state_t;

`ifdef SLOT_REVERSE_REEL_EN
  localparam bit REV_EN = 1'b1;
`else
  localparam bit REV_EN = 1'b0;
`endif
  localparam int IW = NUM_REELS + 2;

  state_t                     state_q, state_d;
  logic [6:0]                 credit_q, credit_d;
  logic [1:0]                 win_q, win_d;
  logic [7:0]                 show_q, show_d;
  logic [IW-1:0]              in_q, prev_q, edge_v;
  logic [NUM_REELS-1:0][3:0]  reel;
  logic [NUM_REELS-1:0]       frozen;
  logic                       clr, run, all_eq, pair;
  logic [7:0]                 add, sub, sum;

  // {STOP, GAME_START, C_IN} registered once, edge against the previous sample
  assign edge_v = in_q & ~prev_q;
  assign run    = (state_q == SPIN);

  for (genvar k = 0; k < NUM_REELS; k++) begin : g_reel
    slot_reel #(
      .DIV     (SPIN_DIV_BASE + 2 * k),
      .SYM_MAX (SYM_MAX),
      .DOWN    (REV_EN && (k % 2 == 1))
    ) u_reel (
      .clk       (CLK),
      .rst_n     (RST),
      .clr       (clr),
      .run       (run),
      .stop_edge (edge_v[k+2]),
      .val       (reel[k]),
      .frozen    (frozen[k])
    );
  end

  always_comb begin
    all_eq = 1'b1;
    pair   = 1'b0;
    for (int i = 0; i < NUM_REELS; i++) begin
      if (reel[i] != reel[0]) all_eq = 1'b0;
      for (int j = i + 1; j < NUM_REELS; j++)
        if (reel[i] == reel[j]) pair = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    show_d  = show_q;
    clr     = 1'b0;
    add     = {7'd0, edge_v[0]};
    sub     = '0;
    case (state_q)
      IDLE: if (edge_v[1] && ({1'b0, credit_q} >= 8'(BET))) begin
        sub     = 8'(BET);
        win_d   = 2'b00;
        clr     = 1'b1;
        state_d = SPIN;
      end
      SPIN: if (&frozen) state_d = EVAL;
      EVAL: begin
        if (all_eq) begin
          win_d = 2'b10;
          add   = add + 8'(ALL_PAYOUT);
        end else if (pair) begin
          win_d = 2'b01;
          add   = add + 8'(PAIR_PAYOUT);
        end else begin
          win_d = 2'b00;
        end
        show_d  = '0;
        state_d = SHOW;
      end
      SHOW: if (show_q == 8'(SHOW_CYCLES - 1)) state_d = IDLE;
            else show_d = show_q + 8'd1;
      default: state_d = IDLE;
    endcase
    // sub only applies when credit >= BET, so the 8-bit sum cannot underflow
    sum      = {1'b0, credit_q} + add - sub;
    credit_d = (sum > 8'(CREDIT_MAX)) ? 7'(CREDIT_MAX) : sum[6:0];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      credit_q <= '0;
      win_q    <= '0;
      show_q   <= '0;
      in_q     <= '0;
      prev_q   <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      win_q    <= win_d;
      show_q   <= show_d;
      in_q     <= {io.STOP, io.GAME_START, io.C_IN};
      prev_q   <= in_q;
    end
  end

  assign io.REEL_VAL   = reel;
  assign io.CREDIT_BIN = credit_q;
  assign io.CREDIT_BCD = {4'(credit_q / 7'd10), 4'(credit_q % 7'd10)};
  assign io.STATE      = state_q;
  assign io.WIN        = win_q;
endmodule

// File: tb/tb_slot_reel_game_ctrl.sv
// Directed vector bench for slot_reel_game_ctrl (3 reels, default parameters).
module tb_slot_reel_game_ctrl;
  localparam logic [1:0] ID = 2'b00, SP = 2'b01, EV = 2'b10, SH = 2'b11;

  typedef struct {
    int         w;
    logic       c_in;
    logic       start;
    logic [2:0] stop;
    logic [1:0] st;
    logic [7:0] bcd;
    logic [1:0] win;
    bit         cr;
    logic [11:0] reel;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vq[$];

  slot_reel_game_ctrl_if #(.NUM_REELS(3)) io();
  slot_reel_game_ctrl dut (.CLK(clk), .RST(rst_n), .io(io));

  always #5 clk = ~clk;

  function automatic vec_t mk(int w, logic c, logic s, logic [2:0] sp, logic [1:0] st,
                              logic [7:0] bcd, logic [1:0] win, bit cr = 1'b0,
                              logic [11:0] reel = 12'h000);
    vec_t v;
    v.w = w; v.c_in = c; v.start = s; v.stop = sp; v.st = st;
    v.bcd = bcd; v.win = win; v.cr = cr; v.reel = reel;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [6:0] bin;
    io.C_IN = v.c_in; io.GAME_START = v.start; io.STOP = v.stop;
    repeat (v.w) @(negedge clk);
    n_vec++;
    bin = 7'(v.bcd[7:4] * 10 + v.bcd[3:0]);
    chk($sformatf("v%0d state", idx), 16'(io.STATE), 16'(v.st));
    chk($sformatf("v%0d bcd", idx), 16'(io.CREDIT_BCD), 16'(v.bcd));
    chk($sformatf("v%0d bin", idx), 16'(io.CREDIT_BIN), 16'(bin));
    chk($sformatf("v%0d win", idx), 16'(io.WIN), 16'(v.win));
    if (v.cr) chk($sformatf("v%0d reel", idx), 16'(io.REEL_VAL), 16'(v.reel));
  endtask

  task automatic coin();
    io.C_IN = 1'b1;
    @(negedge clk);
    io.C_IN = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    io.C_IN = 1'b0; io.GAME_START = 1'b0; io.STOP = '0;
    // reset, start ignored at zero credit, three coins
    vq.push_back(mk(0, 0, 0, 3'b000, ID, 8'h00, 2'b00, 1, 12'h000));
    vq.push_back(mk(1, 0, 1, 3'b000, ID, 8'h00, 2'b00));
    vq.push_back(mk(3, 0, 0, 3'b000, ID, 8'h00, 2'b00, 1, 12'h000));
    vq.push_back(mk(1, 1, 0, 3'b000, ID, 8'h00, 2'b00));
    vq.push_back(mk(2, 0, 0, 3'b000, ID, 8'h01, 2'b00));
    vq.push_back(mk(1, 1, 0, 3'b000, ID, 8'h01, 2'b00));
    vq.push_back(mk(2, 0, 0, 3'b000, ID, 8'h02, 2'b00));
    vq.push_back(mk(1, 1, 0, 3'b000, ID, 8'h02, 2'b00));
    vq.push_back(mk(2, 0, 0, 3'b000, ID, 8'h03, 2'b00));
    // game A: free spin for 40 cycles, then stop at 3,3,5 -> pair
    vq.push_back(mk(1, 0, 1, 3'b000, ID, 8'h03, 2'b00));
    vq.push_back(mk(1, 0, 0, 3'b000, SP, 8'h02, 2'b00, 1, 12'h000));
    vq.push_back(mk(40, 0, 0, 3'b000, SP, 8'h02, 2'b00, 1, 12'h560));
    vq.push_back(mk(12, 0, 0, 3'b100, SP, 8'h02, 2'b00, 1, 12'h583));
    vq.push_back(mk(27, 0, 0, 3'b101, SP, 8'h02, 2'b00, 1, 12'h533));
    vq.push_back(mk(3, 0, 0, 3'b111, EV, 8'h02, 2'b00, 1, 12'h533));
    vq.push_back(mk(1, 0, 0, 3'b111, SH, 8'h07, 2'b01, 1, 12'h533));
    vq.push_back(mk(7, 0, 0, 3'b111, SH, 8'h07, 2'b01));
    vq.push_back(mk(1, 0, 0, 3'b000, ID, 8'h07, 2'b01, 1, 12'h533));
    // game B: reels resume from 5,3,3; stop at 7,7,7 -> all-match
    vq.push_back(mk(1, 0, 1, 3'b000, ID, 8'h07, 2'b01));
    vq.push_back(mk(1, 0, 0, 3'b000, SP, 8'h06, 2'b00, 1, 12'h533));
    vq.push_back(mk(16, 0, 0, 3'b000, SP, 8'h06, 2'b00, 1, 12'h757));
    vq.push_back(mk(9, 0, 0, 3'b101, SP, 8'h06, 2'b00, 1, 12'h777));
    vq.push_back(mk(3, 0, 0, 3'b111, EV, 8'h06, 2'b00, 1, 12'h777));
    vq.push_back(mk(1, 0, 0, 3'b111, SH, 8'h56, 2'b10, 1, 12'h777));
    vq.push_back(mk(7, 0, 0, 3'b111, SH, 8'h56, 2'b10));
    vq.push_back(mk(1, 0, 0, 3'b000, ID, 8'h56, 2'b10));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (vq[i]) apply(vq[i], i);

    // coins up to the ceiling, then one past it
    for (int i = 0; i < 43; i++) coin();
    n_vec++;
    chk("coin to 99", 16'(io.CREDIT_BCD), 16'h0099);
    coin();
    n_vec++;
    chk("coin sat bcd", 16'(io.CREDIT_BCD), 16'h0099);
    chk("coin sat bin", 16'(io.CREDIT_BIN), 16'd99);

    // game C: credit 98, immediate stops at 7,7,7, coin edge lands in EVAL
    apply(mk(1, 0, 1, 3'b000, ID, 8'h99, 2'b10), 100);
    apply(mk(1, 0, 0, 3'b000, SP, 8'h98, 2'b00, 1, 12'h777), 101);
    apply(mk(2, 0, 0, 3'b111, SP, 8'h98, 2'b00, 1, 12'h777), 102);
    apply(mk(1, 1, 0, 3'b111, EV, 8'h98, 2'b00), 103);
    apply(mk(1, 0, 0, 3'b111, SH, 8'h99, 2'b10, 1, 12'h777), 104);
    apply(mk(1, 1, 0, 3'b000, SH, 8'h99, 2'b10), 105);
    apply(mk(2, 0, 0, 3'b000, SH, 8'h99, 2'b10), 106);
    apply(mk(5, 0, 0, 3'b000, ID, 8'h99, 2'b10), 107);

    // game D: reset in the middle of a spin
    apply(mk(1, 0, 1, 3'b000, ID, 8'h99, 2'b10), 108);
    apply(mk(5, 0, 0, 3'b000, SP, 8'h98, 2'b00, 1, 12'h778), 109);
    rst_n = 1'b0;
    #1;
    n_vec++;
    chk("rst state", 16'(io.STATE), 16'(ID));
    chk("rst credit", 16'(io.CREDIT_BIN), 16'd0);
    chk("rst reel", 16'(io.REEL_VAL), 16'h0000);
    chk("rst win", 16'(io.WIN), 16'(2'b00));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // coin and start on the same cycle: start judged on pre-coin credit
    apply(mk(1, 1, 1, 3'b000, ID, 8'h00, 2'b00), 110);
    apply(mk(2, 0, 0, 3'b000, ID, 8'h01, 2'b00), 111);
    apply(mk(1, 1, 1, 3'b000, ID, 8'h01, 2'b00), 112);
    apply(mk(1, 0, 0, 3'b000, SP, 8'h01, 2'b00, 1, 12'h000), 113);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
